// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone multi-master arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_BACKOFF = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_M   = 4;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 64;

    // Ceiling log2, returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// One-hot winner select: rotate requests so ptr+1 sits at bit 0, take the
// lowest set bit, rotate back. Fixed mode uses a zero rotation.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_mode_rr,
    output logic [N-1:0]  o_win
);

    logic [PW:0]    w_sh;
    logic [PW:0]    w_bk;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_low;

    // Rotation amounts are in 0..N; rotating back left by s is rotating right by N-s.
    always_comb begin
        w_sh  = i_mode_rr ? ((PW+1)'(i_ptr) + (PW+1)'(1)) : '0;
        w_bk  = (PW+1)'(N) - w_sh;
        w_rot = N'({i_req, i_req} >> w_sh);
        w_low = w_rot & (~w_rot + N'(1));
        o_win = N'({w_low, w_low} >> w_bk);
    end

endmodule

// File: rtl/wb_multi_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter with per-cycle grant lock,
// runtime round-robin / fixed-priority selection and an ack timeout.
module wb_multi_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_rr_i,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [DW/8*NUM_M-1:0] m_sel_i,
    input  logic [AW*NUM_M-1:0]   m_adr_i,
    input  logic [DW*NUM_M-1:0]   m_dat_i,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic [DW-1:0]         m_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    input  logic                  s_ack_i,
    input  logic [DW-1:0]         s_dat_i,
    output logic [NUM_M-1:0]      grant_o,
    output logic                  busy_o
);

    localparam int SW = DW / 8;
    localparam int PW = (NUM_M > 1) ? clog2(NUM_M) : 1;
    localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_SAT  = (TIMEOUT > 0) ? TW'(TIMEOUT) : '1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    arb_state_e       r_state, w_state_nxt;
    logic [NUM_M-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]    r_rr_ptr, w_ptr_nxt;
    logic [TW-1:0]    r_tmo_cnt, w_tmo_nxt;

    logic [NUM_M-1:0] w_req;
    logic [NUM_M-1:0] w_win;
    logic [PW-1:0]    w_win_idx;
    logic             w_own;
    logic             w_g_cyc, w_g_stb, w_g_we;
    logic [SW-1:0]    w_sel;
    logic [AW-1:0]    w_adr;
    logic [DW-1:0]    w_dat;
    logic             w_ack;
    logic             w_tmo_hit;

    assign w_req = m_cyc_i & m_stb_i;

    rr_pick #(.N(NUM_M), .PW(PW)) u_pick (
        .i_req     (w_req),
        .i_ptr     (r_rr_ptr),
        .i_mode_rr (mode_rr_i),
        .o_win     (w_win)
    );

    // Encode the one-hot winner for the round-robin pointer (OR of set indices).
    always_comb begin
        w_win_idx = '0;
        for (int k = 0; k < NUM_M; k++)
            if (w_win[k]) w_win_idx = w_win_idx | PW'(k);
    end

    // AND-OR mux of the granted master's bus onto the slave side.
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_sel   = '0;
        w_adr   = '0;
        w_dat   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_g_cyc = w_g_cyc | (r_grant[k] & m_cyc_i[k]);
            w_g_stb = w_g_stb | (r_grant[k] & m_stb_i[k]);
            w_g_we  = w_g_we  | (r_grant[k] & m_we_i[k]);
            w_sel   = w_sel | ({SW{r_grant[k]}} & m_sel_i[k*SW +: SW]);
            w_adr   = w_adr | ({AW{r_grant[k]}} & m_adr_i[k*AW +: AW]);
            w_dat   = w_dat | ({DW{r_grant[k]}} & m_dat_i[k*DW +: DW]);
        end
    end

    assign w_own   = (r_state == ST_OWN);
    assign s_cyc_o = w_own & w_g_cyc;
    assign s_stb_o = w_own & w_g_cyc & w_g_stb;
    assign s_we_o  = w_own & w_g_we;
    assign s_sel_o = w_own ? w_sel : '0;
    assign s_adr_o = w_own ? w_adr : '0;
    assign s_dat_o = w_own ? w_dat : '0;
    assign m_dat_o = s_dat_i;

    // Ack beats the timeout when both land on the same cycle.
    assign w_ack     = s_ack_i & s_stb_o;
    assign w_tmo_hit = (TIMEOUT > 0) && s_stb_o && !s_ack_i && (r_tmo_cnt == TMO_LAST);
    assign m_ack_o   = r_grant & {NUM_M{w_ack}};
    assign m_err_o   = r_grant & {NUM_M{w_tmo_hit}};
    assign grant_o   = r_grant;
    assign busy_o    = (r_state != ST_IDLE);

    // Next-state, grant, pointer and timeout counter.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        w_tmo_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (|w_req) begin
                    w_grant_nxt = w_win;
                    w_ptr_nxt   = w_win_idx;
                    w_state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!w_g_cyc) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_BACKOFF;
                end else if (s_stb_o && !s_ack_i) begin
                    w_tmo_nxt = (r_tmo_cnt == TMO_SAT) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
                end
            end
            ST_BACKOFF: begin
                if (!w_g_cyc) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= PW'(NUM_M - 1);
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_ptr_nxt;
            r_tmo_cnt <= w_tmo_nxt;
        end
    end

endmodule

// File: tb/tb_wb_multi_arbiter.sv
// Directed bench for wb_multi_arbiter with a read-data scoreboard.
module tb_wb_multi_arbiter;

    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode_rr = 1'b0;
    logic [NM-1:0]     m_cyc = '0, m_stb = '0, m_we = '0;
    logic [SW*NM-1:0]  m_sel = '0;
    logic [AW*NM-1:0]  m_adr = '0;
    logic [DW*NM-1:0]  m_dat = '0;
    logic              s_ack = 1'b0;
    logic [DW-1:0]     s_dat = '0;

    logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
    logic [DW-1:0]     m_dat_o, s_dat_o;
    logic              s_cyc_o, s_stb_o, s_we_o, busy_o;
    logic [SW-1:0]     s_sel_o;
    logic [AW-1:0]     s_adr_o;

    wb_multi_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .mode_rr_i(mode_rr),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack), .s_dat_i(s_dat),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { int m; logic [31:0] d; } exp_t;
    exp_t exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int k, input bit on, input logic [31:0] adr, input bit we);
        m_cyc[k] = on;
        m_stb[k] = on;
        m_we[k]  = we;
        m_adr[k*AW +: AW] = adr;
        m_sel[k*SW +: SW] = on ? 4'hF : 4'h0;
        m_dat[k*DW +: DW] = ~adr;
    endtask

    // Slave acks this cycle; the granted master must see exactly one ack with this data.
    task automatic beat(input int k, input logic [31:0] d);
        s_ack = 1'b1;
        s_dat = d;
        exp_q.push_back('{m: k, d: d});
    endtask

    // Every master-side ack must match the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (m_ack_o != '0) begin
            if (exp_q.size() == 0) chk("ack_unexpected", 64'(m_ack_o), 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("ack_master", 64'(m_ack_o), 64'(1 << e.m));
                chk("rd_data", 64'(m_dat_o), 64'(e.d));
            end
        end
    end

    initial begin
        tick(); tick();
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_scyc", 64'(s_cyc_o), 64'd0);
        chk("rst_sstb", 64'(s_stb_o), 64'd0);
        chk("rst_mack", 64'(m_ack_o), 64'd0);
        chk("rst_merr", 64'(m_err_o), 64'd0);
        rst_n = 1'b1;

        // Fixed priority, m0 and m2 together
        mode_rr = 1'b0;
        req(0, 1, 32'h100, 0);
        req(2, 1, 32'h200, 0);
        #1 chk("t1_arb_lat", 64'(s_stb_o), 64'd0);
        tick();
        chk("t1_grant", 64'(grant_o), 64'b0001);
        chk("t1_adr", 64'(s_adr_o), 64'h100);
        beat(0, 32'h1111_0000);
        tick();
        s_ack = 1'b0;
        req(0, 0, 0, 0);
        #1 chk("t1_hold", 64'(grant_o), 64'b0001);
        tick();
        chk("t1_dead", 64'(grant_o), 64'd0);
        chk("t1_dead_stb", 64'(s_stb_o), 64'd0);
        tick();
        chk("t1_m2", 64'(grant_o), 64'b0100);
        chk("t1_adr2", 64'(s_adr_o), 64'h200);
        beat(2, 32'h2222_0000);
        tick();
        s_ack = 1'b0;
        req(2, 0, 0, 0);
        tick();
        chk("t1_idle", 64'(busy_o), 64'd0);

        // Round robin from a fresh pointer, all masters requesting
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mode_rr = 1'b1;
        for (int k = 0; k < NM; k++) req(k, 1, 32'h1000 + 32'(k * 16), 0);
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % NM;
            tick();
            chk("t2_grant", 64'(grant_o), 64'(1 << g));
            beat(g, 32'hA0 + 32'(i));
            tick();
            s_ack = 1'b0;
            req(g, 0, 0, 0);
            tick();
            chk("t2_dead", 64'(grant_o), 64'd0);
            req(g, 1, 32'h1000 + 32'(g * 16), 0);
        end
        for (int k = 0; k < NM; k++) req(k, 0, 0, 0);
        tick();
        mode_rr = 1'b0;

        // m1 burst with a stb gap; m0 must not preempt
        req(1, 1, 32'h300, 1);
        tick();
        chk("t3_grant", 64'(grant_o), 64'b0010);
        chk("t3_we", 64'(s_we_o), 64'd1);
        req(0, 1, 32'h400, 0);
        beat(1, 32'h3000);
        tick();
        beat(1, 32'h3001);
        tick();
        m_stb[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            #1;
            chk("t3_gap_stb", 64'(s_stb_o), 64'd0);
            chk("t3_gap_grant", 64'(grant_o), 64'b0010);
            tick();
        end
        m_stb[1] = 1'b1;
        beat(1, 32'h3002);
        tick();
        beat(1, 32'h3003);
        tick();
        s_ack = 1'b0;
        chk("t3_wait", 64'(grant_o), 64'b0010);
        req(1, 0, 0, 0);
        tick();
        chk("t3_dead", 64'(grant_o), 64'd0);
        tick();
        chk("t3_m0", 64'(grant_o), 64'b0001);
        beat(0, 32'h4000);
        tick();
        s_ack = 1'b0;
        req(0, 0, 0, 0);
        tick();

        // Timeout on m2 read, then backoff until cyc drops
        req(2, 1, 32'h500, 0);
        tick();
        chk("t4_grant", 64'(grant_o), 64'b0100);
        for (int c = 1; c <= TMO; c++) begin
            chk("t4_err", 64'(m_err_o), (c == TMO) ? 64'b0100 : 64'd0);
            chk("t4_stb", 64'(s_stb_o), 64'd1);
            if (c < TMO) tick();
        end
        tick();
        chk("t4_bo_cyc", 64'(s_cyc_o), 64'd0);
        chk("t4_bo_busy", 64'(busy_o), 64'd1);
        chk("t4_bo_err", 64'(m_err_o), 64'd0);
        s_ack = 1'b1;
        #1 chk("t4_late_ack", 64'(m_ack_o), 64'd0);
        tick();
        chk("t4_bo_hold", 64'(s_cyc_o), 64'd0);
        s_ack = 1'b0;
        req(2, 0, 0, 0);
        tick();
        chk("t4_idle", 64'(busy_o), 64'd0);

        // Ack lands on the timeout cycle
        req(3, 1, 32'h600, 0);
        tick();
        chk("t5_grant", 64'(grant_o), 64'b1000);
        repeat (TMO - 1) tick();
        beat(3, 32'hDEAD_BEEF);
        #1;
        chk("t5_err", 64'(m_err_o), 64'd0);
        chk("t5_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
        tick();
        s_ack = 1'b0;
        #1 chk("t5_own", 64'(s_cyc_o), 64'd1);
        req(3, 0, 0, 0);
        tick();
        chk("t5_idle", 64'(busy_o), 64'd0);

        // Reset in the middle of a burst
        req(1, 1, 32'h700, 1);
        tick();
        beat(1, 32'h7000);
        tick();
        s_ack = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t6_grant", 64'(grant_o), 64'd0);
        chk("t6_stb", 64'(s_stb_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_regrant", 64'(grant_o), 64'b0010);
        chk("t6_stb2", 64'(s_stb_o), 64'd1);
        req(1, 0, 0, 0);
        tick();
        tick();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
